// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling, stop-bit check,
// one-entry valid/ready holding register with sticky framing and overrun flags.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err,
    output logic       busy
);

    localparam int unsigned HALF     = CLKS_PER_BIT / 2;
    localparam logic [7:0]  HALF_CNT = 8'(HALF - 1);
    localparam logic [7:0]  LAST_CNT = 8'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;

    logic       rx_meta_q;
    logic       rx_s_q;

    logic [2:0] state_q,     state_d;
    logic [7:0] cnt_q,       cnt_d;
    logic [3:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] shift_q,     shift_d;
    logic [7:0] data_q,      data_d;
    logic       valid_q,     valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q,   overrun_d;
    logic       busy_q,      busy_d;

    // Both synchroniser stages reset to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        if (clr_err) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        // Flag set events are assigned after the clear so a coincident set wins.
        case (state_q)
            ST_WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = 8'd0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = 8'd0;
                    if (!rx_s_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 4'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d     = 8'd0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = 8'd0;
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                        if (!valid_q || ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        // A held-low line (break) must rise before another frame is accepted.
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_WAIT_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        busy_d = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_IDLE;
            cnt_q       <= 8'd0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frame scenarios plus randomized frames,
// with a negedge monitor popping expected bytes on every accepted transfer.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic       clrErr;
    logic [7:0] dataOut;
    logic       valid;
    logic       frameErr;
    logic       overrun;
    logic       busy;

    int         totalChecks = 0;
    int         badChecks   = 0;
    int         cycleCount  = 0;
    int         startCycle  = 0;
    int         riseCycle   = -1;
    int         validRises  = 0;
    logic       prevValid   = 1'b0;
    logic [7:0] expByte;
    logic [7:0] expQ[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (dataOut),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frameErr),
        .overrun   (overrun),
        .clr_err   (clrErr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, actual, expected, cycleCount);
        end
    endtask

    // Every transfer (valid && ready seen before the edge) must match the oldest expected byte.
    always @(negedge clk) begin
        if (valid && !prevValid) begin
            validRises++;
            riseCycle = cycleCount;
        end
        prevValid = valid;
        if (!rst && valid && ready) begin
            if (expQ.size() == 0) begin
                totalChecks++;
                badChecks++;
                $display("[TB] FAIL unexpected_byte actual=0x%0h required=none at cycle %0d", dataOut, cycleCount);
            end else begin
                expByte = expQ.pop_front();
                checkOutput("scoreboard_byte", {24'd0, dataOut}, {24'd0, expByte});
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one complete frame; optionally raises ready for exactly the stop-sample cycle.
    task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input logic pulseReady);
        rx = 1'b0;
        startCycle = cycleCount;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            waitCycles(CPB);
        end
        rx = stopBit;
        if (pulseReady) begin
            waitCycles(2 + HALF);
            ready = 1'b1;
            waitCycles(1);
            ready = 1'b0;
            waitCycles(CPB - 3 - HALF);
        end else begin
            waitCycles(CPB);
        end
    endtask

    task automatic waitDrained();
        int n;
        n = 0;
        while (valid && n < 50) begin
            waitCycles(1);
            n++;
        end
        checkOutput("drain_valid", {31'd0, valid}, 32'd0);
    endtask

    task automatic pulseClr();
        clrErr = 1'b1;
        waitCycles(1);
        clrErr = 1'b0;
    endtask

    initial begin
        int         rises0;
        int         latency;
        int         gap;
        logic [7:0] pat;
        logic [7:0] rnd;
        logic       stopBit;
        logic       expFrameErr;

        rx     = 1'b1;
        ready  = 1'b1;
        clrErr = 1'b0;
        rst    = 1'b1;
        waitCycles(3);
        checkOutput("reset_data", {24'd0, dataOut}, 32'd0);
        checkOutput("reset_valid", {31'd0, valid}, 32'd0);
        checkOutput("reset_frame_err", {31'd0, frameErr}, 32'd0);
        checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        waitCycles(5);

        $display("[TB] single frame 0xA5 with latency");
        rises0 = validRises;
        expQ.push_back(8'hA5);
        applyStimulus(8'hA5, 1'b1, 1'b0);
        rx = 1'b1;
        waitCycles(5);
        checkOutput("t1_one_pulse", validRises - rises0, 32'd1);
        latency = riseCycle - startCycle;
        totalChecks++;
        if (latency < 2 + HALF + 9 * CPB - 1 || latency > 2 + HALF + 9 * CPB + 1) begin
            badChecks++;
            $display("[TB] FAIL t1_latency actual=%0d required=%0d+/-1", latency, 2 + HALF + 9 * CPB);
        end
        checkOutput("t1_frame_err", {31'd0, frameErr}, 32'd0);
        checkOutput("t1_busy", {31'd0, busy}, 32'd0);

        $display("[TB] start glitch rejection");
        rises0 = validRises;
        rx = 1'b0;
        waitCycles(3);
        rx = 1'b1;
        waitCycles(HALF + 4);
        checkOutput("t2_busy", {31'd0, busy}, 32'd0);
        checkOutput("t2_no_valid", validRises - rises0, 32'd0);
        expQ.push_back(8'h5A);
        applyStimulus(8'h5A, 1'b1, 1'b0);
        rx = 1'b1;
        waitCycles(3);

        $display("[TB] framing error and break");
        rises0 = validRises;
        applyStimulus(8'h3C, 1'b0, 1'b0);
        waitCycles(40);
        checkOutput("t3_no_valid", validRises - rises0, 32'd0);
        checkOutput("t3_frame_err", {31'd0, frameErr}, 32'd1);
        checkOutput("t3_no_restart", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        waitCycles(3);
        pulseClr();
        checkOutput("t3_clr", {31'd0, frameErr}, 32'd0);
        expQ.push_back(8'h81);
        applyStimulus(8'h81, 1'b1, 1'b0);
        rx = 1'b1;
        waitCycles(5);
        checkOutput("t3_after_frame_err", {31'd0, frameErr}, 32'd0);

        $display("[TB] overrun with stalled consumer");
        ready = 1'b0;
        expQ.push_back(8'h11);
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0);
        rx = 1'b1;
        waitCycles(2);
        checkOutput("t4_data", {24'd0, dataOut}, 32'h11);
        checkOutput("t4_valid", {31'd0, valid}, 32'd1);
        checkOutput("t4_overrun", {31'd0, overrun}, 32'd1);
        ready = 1'b1;
        waitCycles(1);
        ready = 1'b0;
        checkOutput("t4_valid_clear", {31'd0, valid}, 32'd0);
        checkOutput("t4_data_held", {24'd0, dataOut}, 32'h11);
        pulseClr();
        checkOutput("t4_overrun_clr", {31'd0, overrun}, 32'd0);

        $display("[TB] consume and load in the same cycle");
        expQ.push_back(8'h66);
        applyStimulus(8'h66, 1'b1, 1'b0);
        expQ.push_back(8'h77);
        applyStimulus(8'h77, 1'b1, 1'b1);
        rx = 1'b1;
        waitCycles(2);
        checkOutput("t5_valid", {31'd0, valid}, 32'd1);
        checkOutput("t5_data", {24'd0, dataOut}, 32'h77);
        checkOutput("t5_overrun", {31'd0, overrun}, 32'd0);
        ready = 1'b1;
        waitCycles(2);
        checkOutput("t5_drained", {31'd0, valid}, 32'd0);

        $display("[TB] reset in the middle of a frame");
        rises0 = validRises;
        pat = 8'hF0;
        rx = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = pat[i];
            waitCycles(CPB);
        end
        rx = pat[4];
        waitCycles(HALF);
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        checkOutput("t6_data", {24'd0, dataOut}, 32'd0);
        checkOutput("t6_valid", {31'd0, valid}, 32'd0);
        checkOutput("t6_frame_err", {31'd0, frameErr}, 32'd0);
        checkOutput("t6_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("t6_busy", {31'd0, busy}, 32'd0);
        for (int i = 5; i < 8; i++) begin
            rx = pat[i];
            waitCycles(CPB);
        end
        rx = 1'b1;
        waitCycles(CPB + 20);
        checkOutput("t6_no_valid", validRises - rises0, 32'd0);
        expQ.push_back(8'h0F);
        applyStimulus(8'h0F, 1'b1, 1'b0);
        rx = 1'b1;
        waitCycles(5);

        $display("[TB] randomized frames");
        expFrameErr = 1'b0;
        for (int n = 0; n < 16; n++) begin
            rnd     = 8'($urandom_range(0, 255));
            stopBit = ($urandom_range(0, 4) != 0);
            if (stopBit) begin
                expQ.push_back(rnd);
            end else begin
                expFrameErr = 1'b1;
            end
            fork
                applyStimulus(rnd, stopBit, 1'b0);
                begin
                    repeat (10 * CPB - 1) begin
                        ready = 1'($urandom_range(0, 1));
                        waitCycles(1);
                    end
                end
            join
            ready = 1'b1;
            rx    = 1'b1;
            waitDrained();
            gap = stopBit ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
            if (gap > 0) begin
                waitCycles(gap);
            end
        end
        rx = 1'b1;
        waitCycles(5);
        checkOutput("rand_frame_err", {31'd0, frameErr}, {31'd0, expFrameErr});
        checkOutput("rand_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("queue_empty", expQ.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
